io_tx_fifo: RTL and testbench
=============================

// Module: io_tx_fifo
// PURPOSE
// - Downstream of cpu on the memory/IO bus: captures CPU byte writes to the UART port (0x30000),
//   buffers them in a FIFO and drives a valid/ready byte stream toward the UART transmitter.
// - Produces io_buffer_full back to cpu, with a safety margin for writes already in flight.
// - Handles the program-stop write (0x30004): drains pending bytes, emits '\0', then halts.
// PARAMETERS
// - DEPTH_WIDTH  4  log2 of FIFO entries (16 entries)
// - FULL_MARGIN  2  io_buffer_full asserts when free entries <= FULL_MARGIN; range 1..DEPTH-1
// PORTS
// - clk_in          in   1   system clock
// - rst_in          in   1   asynchronous, active-low reset
// - rdy_in          in   1   cpu ready; bus writes are sampled only when high
// - mem_a           in   32  cpu address bus; only [17:16] and [2:0] decoded
// - mem_wr          in   1   1 = write
// - mem_dout        in   8   cpu write data
// - io_buffer_full  out  1   back-pressure to cpu
// - tx_valid        out  1   head byte valid
// - tx_data         out  8   head byte (first-word-fall-through)
// - tx_ready        in   1   UART accepts head byte this cycle
// - program_stop    out  1   sticky; program finished and terminator sent
// - overflow        out  1   sticky; a byte was dropped on a full FIFO
// - tx_count        out  32  bytes handed to UART (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst_in low, async): FIFO empty, ptrs/count 0, state RUN; io_buffer_full=0, tx_valid=0,
//   tx_data=0, program_stop=0, overflow=0, tx_count=0.
// - Decode: io_wr = rdy_in & mem_wr & (mem_a[17:16]==2'b11). Data write: io_wr & mem_a[2:0]==0.
//   Stop write: io_wr & mem_a[2:0]==4. Reads and non-IO addresses are ignored.
// - Push: data write in state RUN with mem_dout != 8'h00 -> enqueue at clock edge. 0x00 ignored.
// - Pop: tx_valid & tx_ready -> dequeue at clock edge; independent of rdy_in.
// - tx_valid = (count != 0); tx_data = mem[rd_ptr]; both registered-state derived, no comb path
//   from tx_ready or bus inputs.
// - Simultaneous push+pop: both occur, count unchanged; legal at full and at empty? only when
//   count>=1 (pop needs valid); push to empty FIFO visible on tx_valid the next cycle.
// - Full (count==DEPTH) push without same-cycle pop: byte dropped, overflow<=1. Push+pop at full
//   is accepted.
// - io_buffer_full = (DEPTH - count) <= FULL_MARGIN, from registered count only.
// - Pointers DEPTH_WIDTH bits, wrap naturally mod DEPTH; count DEPTH_WIDTH+1 bits.
// - FSM:
//   RUN   : stop write -> enqueue 8'h00 terminator (overflow rule applies) and go DRAIN.
//           Data and stop write same cycle cannot occur (one address).
//   DRAIN : all further bus writes ignored; pops continue. When terminator popped
//           (count==1 & pop) -> HALT.
//   HALT  : program_stop=1 (registered, asserted cycle after terminator pop); writes ignored;
//           only reset leaves HALT.
// - If terminator is dropped on full FIFO: go DRAIN anyway, HALT when count reaches 0.
// - rdy_in low: no pushes, no state change from bus; UART side continues draining.
// - Reset mid-transfer: FIFO contents discarded, tx_valid drops asynchronously.
// CONFIGURATION
// - IO_TX_STATS_EN defined: tx_count increments on every pop (wraps at 2^32), incl. terminator.
// - Not defined: tx_count tied to 32'h0, no counter flops.
// TESTING
// - Write 'A','B','C' to 0x30000, tx_ready=1 -> tx_data 0x41,0x42,0x43 in order, tx_valid then 0.
// - Write 0x00 to 0x30000 -> no push, tx_valid stays 0, count 0.
// - tx_ready=0, 14 writes (DEPTH 16, margin 2) -> io_buffer_full=1 after 14th; 17th write
//   with no pop -> dropped, overflow=1, count=16.
// - Fill to 16, then write with tx_ready=1 same cycle -> accepted, count stays 16, overflow=0.
// - Write 'X', then write to 0x30004, then 'Y' -> stream 0x58,0x00; 'Y' ignored; program_stop=1
//   cycle after 0x00 popped; IO_TX_STATS_EN build shows tx_count=2.
// - Assert rst_in low mid-drain -> tx_valid=0, program_stop=0, count 0 immediately.

Source files
------------

// File: rtl/io_tx_fifo.sv
// +--------------------------------------------------------------------------+
// | io_tx_fifo : captures CPU byte writes to the UART port into a FIFO and    |
// | streams them out valid/ready. Optional tx_count via IO_TX_STATS_EN.      |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module io_tx_fifo #(
  parameter int DEPTH_WIDTH = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_stop,
  output logic        overflow,
  output logic [31:0] tx_count
);

  localparam int unsigned              c_depth       = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]     c_depth_cnt   = (DEPTH_WIDTH+1)'(c_depth);
  localparam logic [DEPTH_WIDTH:0]     c_full_thresh = (DEPTH_WIDTH+1)'(c_depth - FULL_MARGIN);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DEPTH_WIDTH:0]   count_q, count_d;
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]             mem_q [c_depth];
  logic                   overflow_q;

  logic       w_io_wr, w_data_wr, w_stop_wr;
  logic       w_pop, w_full;
  logic       w_push_req, w_push_ok, w_drop;
  logic [7:0] w_push_byte;
  logic       w_unused_addr;

  assign w_io_wr       = rdy_in & mem_wr & (mem_a[17:16] == 2'b11);
  assign w_data_wr     = w_io_wr & (mem_a[2:0] == 3'd0);
  assign w_stop_wr     = w_io_wr & (mem_a[2:0] == 3'd4);
  assign w_unused_addr = ^{mem_a[31:18], mem_a[15:3]};

  assign w_pop     = (count_q != '0) & tx_ready;
  assign w_full    = (count_q == c_depth_cnt);
  // A pop in the same cycle frees the slot, so a push at full still fits.
  assign w_push_ok = w_push_req & (~w_full | w_pop);
  assign w_drop    = w_push_req & w_full & ~w_pop;

  always_comb begin
    state_d     = state_q;
    w_push_req  = 1'b0;
    w_push_byte = 8'h00;
    case (state_q)
      ST_RUN: begin
        if (w_data_wr && (mem_dout != 8'h00)) begin
          w_push_req  = 1'b1;
          w_push_byte = mem_dout;
        end else if (w_stop_wr) begin
          w_push_req = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      // Also covers a dropped terminator: the last real byte empties the FIFO.
      ST_DRAIN: if (w_pop && (count_q == (DEPTH_WIDTH+1)'(1))) state_d = ST_HALT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({w_push_ok, w_pop})
      2'b10:   count_d = count_q + (DEPTH_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_RUN;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_WIDTH'(1);
      if (w_pop)     rd_ptr_q <= rd_ptr_q + DEPTH_WIDTH'(1);
      if (w_drop)    overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(c_depth); i++) mem_q[i] <= 8'h00;
    end else if (w_push_ok) begin
      mem_q[wr_ptr_q] <= w_push_byte;
    end
  end

  assign tx_valid       = (count_q != '0);
  assign tx_data        = mem_q[rd_ptr_q];
  assign io_buffer_full = (count_q >= c_full_thresh);
  assign program_stop   = (state_q == ST_HALT);
  assign overflow       = overflow_q;

`ifdef IO_TX_STATS_EN
  logic [31:0] tx_count_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)    tx_count_q <= 32'h0;
    else if (w_pop) tx_count_q <= tx_count_q + 32'd1;
  end

  assign tx_count = tx_count_q;
`else
  assign tx_count = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_tx_fifo.sv
// +--------------------------------------------------------------------------+
// | tb_io_tx_fifo : directed + randomized bench for io_tx_fifo against a     |
// | queue-based reference model. Revision : 1.0                              |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_io_tx_fifo;

  localparam logic [31:0] c_io_data = 32'h0003_0000;
  localparam logic [31:0] c_io_stop = 32'h0003_0004;
  localparam int          c_depth   = 16;
  localparam int          c_margin  = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic        tx_ready = 1'b0;
  logic        io_buffer_full, tx_valid, program_stop, overflow;
  logic [7:0]  tx_data;
  logic [31:0] tx_count;

  int checks = 0;
  int errors = 0;

  io_tx_fifo #(.DEPTH_WIDTH(4), .FULL_MARGIN(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
    .mem_wr(mem_wr), .mem_dout(mem_dout), .io_buffer_full(io_buffer_full),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .program_stop(program_stop), .overflow(overflow), .tx_count(tx_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending bytes plus run/drain/halt phase.
  logic [7:0]  mq[$];
  int          m_phase = 0;  // 0 running, 1 draining, 2 halted
  logic        m_ovf = 1'b0;
  logic [31:0] m_cnt = '0;
  logic        m_pop, m_iow, m_dw, m_sw, m_want, m_was_full;
  logic [7:0]  m_byte;
  int          m_old_phase;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mq.delete();
      m_phase = 0;
      m_ovf   = 1'b0;
      m_cnt   = '0;
    end else begin
      m_old_phase = m_phase;
      m_was_full  = (mq.size() == c_depth);
      m_pop  = (mq.size() != 0) && tx_ready;
      m_iow  = rdy_in && mem_wr && (mem_a[17:16] == 2'b11);
      m_dw   = m_iow && (mem_a[2:0] == 3'd0);
      m_sw   = m_iow && (mem_a[2:0] == 3'd4);
      m_want = 1'b0;
      m_byte = 8'h00;
      if (m_old_phase == 0) begin
        if (m_dw && mem_dout != 8'h00) begin m_want = 1'b1; m_byte = mem_dout; end
        else if (m_sw) begin m_want = 1'b1; m_phase = 1; end
      end
      if (m_pop) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (m_want) begin
        if (!m_was_full || m_pop) mq.push_back(m_byte);
        else m_ovf = 1'b1;
      end
      if (m_old_phase == 1 && m_pop && mq.size() == 0) m_phase = 2;
    end
  end

  always @(negedge clk_in) begin
    check("tx_valid", tx_valid, mq.size() != 0);
    if (mq.size() != 0) check("tx_data", tx_data, mq[0]);
    check("io_buffer_full", io_buffer_full, (c_depth - mq.size()) <= c_margin);
    check("program_stop", program_stop, m_phase == 2);
    check("overflow", overflow, m_ovf);
`ifdef IO_TX_STATS_EN
    check("tx_count", tx_count, m_cnt);
`else
    check("tx_count", tx_count, 32'h0);
`endif
  end

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    rdy_in = 1'b1; mem_wr = 1'b1; mem_a = a; mem_dout = d;
    @(posedge clk_in); #1;
    mem_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          sel;

    // Reset state
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_data", tx_data, 8'h00);
    check("rst io_buffer_full", io_buffer_full, 0);
    check("rst program_stop", program_stop, 0);
    check("rst overflow", overflow, 0);
    check("rst tx_count", tx_count, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // 'A','B','C' stream in order
    bus_wr(c_io_data, 8'h41);
    bus_wr(c_io_data, 8'h42);
    bus_wr(c_io_data, 8'h43);
    tx_ready = 1'b1;
    @(negedge clk_in); check("abc first", tx_data, 8'h41); check("abc valid", tx_valid, 1);
    @(negedge clk_in); check("abc second", tx_data, 8'h42);
    @(negedge clk_in); check("abc third", tx_data, 8'h43);
    @(negedge clk_in); check("abc empty", tx_valid, 0);
    @(posedge clk_in); #1;
    tx_ready = 1'b0;

    // 0x00 data byte ignored
    bus_wr(c_io_data, 8'h00);
    @(negedge clk_in); check("zero ignored", tx_valid, 0);
    @(posedge clk_in); #1;

    // Fill, margin and overflow
    for (int i = 0; i < 13; i++) bus_wr(c_io_data, 8'h60 + 8'(i));
    @(negedge clk_in); check("ibf at 13", io_buffer_full, 0);
    @(posedge clk_in); #1;
    bus_wr(c_io_data, 8'h6D);
    @(negedge clk_in); check("ibf at 14", io_buffer_full, 1);
    @(posedge clk_in); #1;
    bus_wr(c_io_data, 8'h6E);
    bus_wr(c_io_data, 8'h6F);
    @(negedge clk_in); check("ovf at 16", overflow, 0);
    @(posedge clk_in); #1;
    bus_wr(c_io_data, 8'h70);
    @(negedge clk_in); check("ovf at 17", overflow, 1); check("head after drop", tx_data, 8'h60);
    @(posedge clk_in); #1;
    tx_ready = 1'b1;
    repeat (18) @(posedge clk_in); #1;
    tx_ready = 1'b0;
    @(negedge clk_in); check("drained", tx_valid, 0);
    @(posedge clk_in); #1;

    // Push+pop at full accepted
    do_reset();
    for (int i = 0; i < 16; i++) bus_wr(c_io_data, 8'h10 + 8'(i));
    rdy_in = 1'b1; mem_wr = 1'b1; mem_a = c_io_data; mem_dout = 8'hEE; tx_ready = 1'b1;
    @(posedge clk_in); #1;
    mem_wr = 1'b0; tx_ready = 1'b0;
    @(negedge clk_in);
    check("full pp ovf", overflow, 0);
    check("full pp ibf", io_buffer_full, 1);
    check("full pp head", tx_data, 8'h11);
    @(posedge clk_in); #1;
    tx_ready = 1'b1;
    repeat (20) @(posedge clk_in); #1;
    tx_ready = 1'b0;

    // Stop sequence
    do_reset();
    bus_wr(c_io_data, 8'h58);
    bus_wr(c_io_stop, 8'hAB);
    bus_wr(c_io_data, 8'h59);
    tx_ready = 1'b1;
    @(negedge clk_in); check("stop X", tx_data, 8'h58);
    @(negedge clk_in); check("stop term", tx_data, 8'h00); check("stop valid", tx_valid, 1);
    check("stop not yet", program_stop, 0);
    @(negedge clk_in); check("stop empty", tx_valid, 0); check("stop set", program_stop, 1);
`ifdef IO_TX_STATS_EN
    check("stop count", tx_count, 32'd2);
`else
    check("stop count", tx_count, 32'd0);
`endif
    @(posedge clk_in); #1;
    bus_wr(c_io_data, 8'h5A);
    @(negedge clk_in); check("halt ignores", tx_valid, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0; #1;
    check("halt rst stop", program_stop, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // Reset mid-drain
    tx_ready = 1'b0;
    bus_wr(c_io_data, 8'h31);
    bus_wr(c_io_data, 8'h32);
    bus_wr(c_io_data, 8'h33);
    bus_wr(c_io_stop, 8'h00);
    tx_ready = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0; #1;
    check("middrain valid", tx_valid, 0);
    check("middrain stop", program_stop, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b1; tx_ready = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      sel  = $urandom_range(0, 299);
      addr = $urandom;
      if (sel < 200) begin addr[17:16] = 2'b11; addr[2:0] = 3'd0; end
      else if (sel < 202) begin addr[17:16] = 2'b11; addr[2:0] = 3'd4; end
      mem_a    = addr;
      rdy_in   = ($urandom_range(0, 3) != 0);
      mem_wr   = 1'($urandom_range(0, 1));
      mem_dout = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if (((c / 250) % 2) == 0) tx_ready = ($urandom_range(0, 3) == 0);
      else                      tx_ready = ($urandom_range(0, 3) != 0);
      rst_in = !(($urandom_range(0, 399) == 0) || (c % 800 == 799));
      @(posedge clk_in); #1;
    end
    rst_in = 1'b1; mem_wr = 1'b0; tx_ready = 1'b1;
    repeat (20) @(posedge clk_in);
    @(negedge clk_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
